// File: rtl/booth2_pkg.sv
// Shared constants, state encoding and sign-extension helper for the radix-4 Booth
// partial-product accumulator and its sub-modules.
package booth2_pkg;

    localparam int NUM_PP = 8;
    localparam int PP_W   = 17;
    localparam int OUT_W  = 2 * (PP_W - 1);
    localparam int CNT_W  = $clog2(NUM_PP);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] sext_pp(input logic [PP_W-1:0] pp);
        return {{(OUT_W - PP_W){pp[PP_W-1]}}, pp};
    endfunction

endpackage

// File: rtl/booth2_pp_shift_ext.sv
// Combinational sign-extend of one raw partial product to product width, then shift
// by 2*idx so the PP lands at its radix-4 weight.
module booth2_pp_shift_ext
    import booth2_pkg::*;
(
    input  logic [PP_W-1:0]  pp,
    input  logic [CNT_W-1:0] shift_idx,
    output logic [OUT_W-1:0] term
);

    logic [CNT_W:0] shamt;

    always_comb begin
        shamt = {shift_idx, 1'b0};
        term  = sext_pp(pp) << shamt;
    end

endmodule

// File: rtl/booth2_pp_accum.sv
// Serial radix-4 Booth partial-product accumulator: one PP per clock into a wrapping
// 32-bit accumulator. Optional macro ZERO_SKIP_EN ends early once the remaining PPs are zero.
module booth2_pp_accum
    import booth2_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_PP*PP_W-1:0] pp_bus,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       product,
    output logic                   busy
);

    state_t           state;
    logic [PP_W-1:0]  pp_reg [NUM_PP];
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] term;
    logic             acc_done;

    booth2_pp_shift_ext u_shift_ext (
        .pp        (pp_reg[cnt]),
        .shift_idx (cnt),
        .term      (term)
    );

`ifdef ZERO_SKIP_EN
    logic rest_zero;

    // True when every PP at or above the current index is zero, so acc is already final.
    always_comb begin
        rest_zero = 1'b1;
        for (int i = 0; i < NUM_PP; i++) begin
            if (CNT_W'(i) >= cnt && pp_reg[i] != '0) begin
                rest_zero = 1'b0;
            end
        end
    end
`endif

    // acc_done marks that acc holds the full sum; the following edge moves it to PRODUCT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            acc_done  <= 1'b0;
            for (int i = 0; i < NUM_PP; i++) begin
                pp_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < NUM_PP; i++) begin
                            pp_reg[i] <= pp_bus[i*PP_W +: PP_W];
                        end
                        acc      <= '0;
                        cnt      <= '0;
                        acc_done <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (acc_done) begin
                        product   <= acc;
                        out_valid <= 1'b1;
                        acc_done  <= 1'b0;
                        state     <= DONE;
`ifdef ZERO_SKIP_EN
                    end else if (rest_zero) begin
                        acc_done <= 1'b1;
`endif
                    end else begin
                        acc <= acc + term;
                        if (cnt == LAST_CNT) begin
                            acc_done <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth2_pp_accum.sv
// Directed self-checking bench for booth2_pp_accum; latency expectations follow ZERO_SKIP_EN.
module tb_booth2_pp_accum;
    import booth2_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_PP*PP_W-1:0] pp_bus;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       product;
    logic                   busy;

    int total = 0;
    int bad   = 0;

    booth2_pp_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp_bus    (pp_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_pp(input int k, input logic [PP_W-1:0] v);
        pp_bus[(k-1)*PP_W +: PP_W] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present the bundle on pp_bus for one edge; in_ready must be high for the accept.
    task automatic accept_bundle(input string name);
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_in_ready: got %b expected 1", name, in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        pp_bus = '0;
        for (n = 0; n < 2; n++) step();
        rst = 1'b0;
        total += 4;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (product !== 32'h0) begin bad++; $display("[TB] FAIL rst_product: got %h expected 00000000", product); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int n;
        int exp_lat;
`ifdef ZERO_SKIP_EN
        exp_lat = 4;
`else
        exp_lat = 9;
`endif
        pp_bus = '0;
        set_pp(1, 17'h1FFFB);
        set_pp(2, 17'h00005);
        out_ready = 1'b1;
        accept_bundle("basic");
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_in_ready_low: got %b expected 0", in_ready); end
        pp_bus = '0;
        wait_valid(n);
        total += 2;
        if (n !== exp_lat) begin bad++; $display("[TB] FAIL basic_latency: got %0d expected %0d", n, exp_lat); end
        if (product !== 32'h0000000F) begin bad++; $display("[TB] FAIL basic_product: got %h expected 0000000f", product); end
        step();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_consumed: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_back_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_negative();
        int n;
        pp_bus = '0;
        set_pp(1, 17'h18001);
        accept_bundle("neg");
        wait_valid(n);
        total++;
        if (product !== 32'hFFFF8001) begin bad++; $display("[TB] FAIL neg_product: got %h expected ffff8001", product); end
        step();
    endtask

    task automatic test_stall();
        int n;
        pp_bus = '0;
        set_pp(1, 17'h18001);
        set_pp(8, 17'h0FFFE);
        out_ready = 1'b0;
        accept_bundle("stall");
        wait_valid(n);
        total += 2;
        if (n !== 9) begin bad++; $display("[TB] FAIL stall_latency: got %0d expected 9", n); end
        if (product !== 32'h3FFF0001) begin bad++; $display("[TB] FAIL stall_product: got %h expected 3fff0001", product); end
        for (int i = 0; i < 5; i++) begin
            step();
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold_valid: cycle %0d got %b expected 1", i, out_valid); end
            if (product !== 32'h3FFF0001) begin bad++; $display("[TB] FAIL stall_hold_product: cycle %0d got %h expected 3fff0001", i, product); end
            if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready: cycle %0d got %b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_release: got %b expected 0", out_valid); end
    endtask

    task automatic test_ignore_busy();
        int n;
        pp_bus = '0;
        set_pp(1, 17'h1FFFB);
        set_pp(2, 17'h00005);
        accept_bundle("ign");
        step();
        pp_bus = '0;
        set_pp(1, 17'h18001);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ign_in_ready: cycle %0d got %b expected 0", i, in_ready); end
            step();
        end
        in_valid = 1'b0;
        wait_valid(n);
        total++;
        if (product !== 32'h0000000F) begin bad++; $display("[TB] FAIL ign_product: got %h expected 0000000f", product); end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        pp_bus = '0;
        set_pp(1, 17'h18001);
        set_pp(8, 17'h0FFFE);
        accept_bundle("rmid");
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total += 4;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_out_valid: got %b expected 0", out_valid); end
        if (product !== 32'h0) begin bad++; $display("[TB] FAIL rmid_product: got %h expected 00000000", product); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_no_output: cycle %0d got %b expected 0", i, out_valid); end
        end
        pp_bus = '0;
        set_pp(1, 17'h18001);
        accept_bundle("rmid_fresh");
        wait_valid(n);
        total++;
        if (product !== 32'hFFFF8001) begin bad++; $display("[TB] FAIL rmid_fresh_product: got %h expected ffff8001", product); end
        step();
    endtask

    task automatic test_zero_bundle();
        int n;
        int exp_lat;
`ifdef ZERO_SKIP_EN
        exp_lat = 2;
`else
        exp_lat = 9;
`endif
        pp_bus = '0;
        accept_bundle("zero");
        wait_valid(n);
        total += 2;
        if (n !== exp_lat) begin bad++; $display("[TB] FAIL zero_latency: got %0d expected %0d", n, exp_lat); end
        if (product !== 32'h0) begin bad++; $display("[TB] FAIL zero_product: got %h expected 00000000", product); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_stall();
        test_ignore_busy();
        test_reset_mid();
        test_zero_bundle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
